// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU sequencer: state encoding and
// operand/result sizing.
package tpu_pkg;

    localparam int DATA_W      = 8;
    localparam int RESULT_W    = 16;
    localparam int N_OPERANDS  = 8;
    localparam int N_OUT_BYTES = 8;
    localparam int ADDR_W      = 3;

    typedef enum logic [2:0] {
        LOAD    = 3'd0,
        CLEAR   = 3'd1,
        COMPUTE = 3'd2,
        CAPTURE = 3'd3,
        OUTPUT  = 3'd4
    } state_t;

endpackage

// File: rtl/result_serializer.sv
// Snapshots the four array results on start and streams them out as bytes
// (little-endian per result, row-major) under a valid/ready handshake.
module result_serializer
    import tpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [RESULT_W-1:0] c00,
    input  logic [RESULT_W-1:0] c01,
    input  logic [RESULT_W-1:0] c10,
    input  logic [RESULT_W-1:0] c11,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    output logic                last
);

    localparam int CNT_W = $clog2(N_OUT_BYTES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_OUT_BYTES - 1);

    logic [4*RESULT_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0]      out_cnt_q, out_cnt_d;
    logic                  valid_q, valid_d;
    logic                  xfer;

    always_comb begin
        shadow_d  = shadow_q;
        out_cnt_d = out_cnt_q;
        valid_d   = valid_q;
        xfer      = valid_q && out_ready;
        last      = xfer && (out_cnt_q == CNT_LAST);
        if (start) begin
            // c00 lands in the lowest bytes so out_cnt indexes bytes directly
            shadow_d  = {c11, c10, c01, c00};
            out_cnt_d = '0;
            valid_d   = 1'b1;
        end else if (last) begin
            out_cnt_d = '0;
            valid_d   = 1'b0;
        end else if (xfer) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q  <= '0;
            out_cnt_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            out_cnt_q <= out_cnt_d;
            valid_q   <= valid_d;
        end
    end

    assign out_data  = shadow_q[int'(out_cnt_q) * DATA_W +: DATA_W];
    assign out_valid = valid_q;

endmodule

// File: rtl/tpu_control_unit.sv
// Sequencer between the host byte stream, the operand memory and the 2x2
// systolic array: load operands, clear, compute, capture, serialise results.
module tpu_control_unit
    import tpu_pkg::*;
#(
    parameter int COMPUTE_CYCLES = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_en,
    input  logic [DATA_W-1:0]   in_data,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mmu_clear,
    output logic                mmu_en,
    input  logic [RESULT_W-1:0] c00,
    input  logic [RESULT_W-1:0] c01,
    input  logic [RESULT_W-1:0] c10,
    input  logic [RESULT_W-1:0] c11,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done
);

    localparam int CYC_W = $clog2(COMPUTE_CYCLES + 1);
    localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(COMPUTE_CYCLES - 1);
    localparam logic [CYC_W-1:0]  CYC_END   = CYC_W'(COMPUTE_CYCLES);
    localparam logic [ADDR_W-1:0] LOAD_LAST = ADDR_W'(N_OPERANDS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] load_cnt_q, load_cnt_d;
    logic [CYC_W-1:0]  cyc_cnt_q, cyc_cnt_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              ser_start;
    logic              ser_last;

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        cyc_cnt_d  = cyc_cnt_q;
        mem_we     = 1'b0;
        mmu_clear  = 1'b0;
        mmu_en     = 1'b0;
        ser_start  = 1'b0;
        case (state_q)
            LOAD: begin
                mem_we = load_en;
                if (load_en) begin
                    if (load_cnt_q == LOAD_LAST) begin
                        load_cnt_d = '0;
                        state_d    = CLEAR;
                    end else begin
                        load_cnt_d = load_cnt_q + 1'b1;
                    end
                end
            end
            CLEAR: begin
                mmu_clear = 1'b1;
                cyc_cnt_d = '0;
                state_d   = COMPUTE;
            end
            COMPUTE: begin
                mmu_en    = (cyc_cnt_q < CYC_END);
                cyc_cnt_d = cyc_cnt_q + 1'b1;
                if (cyc_cnt_q == CYC_LAST) state_d = CAPTURE;
            end
            CAPTURE: begin
                ser_start = 1'b1;
                state_d   = OUTPUT;
            end
            OUTPUT: begin
                if (ser_last) state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
        done_d = ser_last;
        // Decoded from the next state so busy tracks state_q with no extra lag
        busy_d = (state_d != LOAD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= LOAD;
            load_cnt_q <= '0;
            cyc_cnt_q  <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            cyc_cnt_q  <= cyc_cnt_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign mem_addr  = load_cnt_q;
    assign mem_wdata = in_data;
    assign done      = done_q;
    assign busy      = busy_q;

    result_serializer u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (ser_start),
        .c00       (c00),
        .c01       (c01),
        .c10       (c10),
        .c11       (c11),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .last      (ser_last)
    );

endmodule

// File: tb/tb_tpu_control_unit.sv
// Directed bench for tpu_control_unit: load, compute, serialise, stalls,
// ignored strobes and mid-operation reset.
module tb_tpu_control_unit;

    logic        clk;
    logic        rst_n;
    logic        load_en;
    logic [7:0]  in_data;
    logic        mem_we;
    logic [2:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mmu_clear;
    logic        mmu_en;
    logic [15:0] c00, c01, c10, c11;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    int total;
    int bad;

    tpu_control_unit #(.COMPUTE_CYCLES(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (load_en),
        .in_data   (in_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mmu_clear (mmu_clear),
        .mmu_en    (mmu_en),
        .c00       (c00),
        .c01       (c01),
        .c10       (c10),
        .c11       (c11),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Loads 8 bytes base..base+7; gaps applies the strobe pattern 1,0,1,1,0.
    // Returns one cycle into CLEAR.
    task automatic do_load(input bit gaps, input logic [7:0] base);
        int n;
        int cyc;
        bit pat;
        logic [7:0] expd;
        n = 0;
        cyc = 0;
        while (n < 8 && cyc < 64) begin
            @(negedge clk);
            pat = gaps ? !((cyc % 5) == 1 || (cyc % 5) == 4) : 1'b1;
            expd = base + 8'(n);
            load_en = pat;
            in_data = pat ? expd : 8'hFF;
            #1;
            if (pat) begin
                total++;
                if (mem_we !== 1'b1 || mem_addr !== 3'(n) || mem_wdata !== expd) begin
                    bad++;
                    $display("FAIL load_write[%0d]: got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                             n, mem_we, mem_addr, mem_wdata, n, expd);
                end
                total++;
                if (busy !== 1'b0) begin
                    bad++;
                    $display("FAIL load_busy[%0d]: got %b want 0", n, busy);
                end
                n++;
            end else begin
                total++;
                if (mem_we !== 1'b0) begin
                    bad++;
                    $display("FAIL load_idle_we[cyc %0d]: got %b want 0", cyc, mem_we);
                end
            end
            cyc++;
        end
        total++;
        if (n != 8) begin
            bad++;
            $display("FAIL load_count: got %0d bytes want 8", n);
        end
        @(negedge clk);
        load_en = 1'b0;
        #1;
        total++;
        if (busy !== 1'b1 || mmu_clear !== 1'b1 || mem_we !== 1'b0 || mmu_en !== 1'b0) begin
            bad++;
            $display("FAIL clear_cycle: got busy=%b clear=%b we=%b en=%b want busy=1 clear=1 we=0 en=0",
                     busy, mmu_clear, mem_we, mmu_en);
        end
    endtask

    // From the CLEAR cycle: 5 compute cycles, then CAPTURE with the results driven.
    task automatic do_compute(input logic [15:0] r0, input logic [15:0] r1,
                              input logic [15:0] r2, input logic [15:0] r3,
                              input bit pulse);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            load_en = pulse;
            in_data = 8'h77;
            #1;
            total++;
            if (mmu_en !== 1'b1 || mmu_clear !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL compute[%0d]: got en=%b clear=%b we=%b busy=%b want en=1 clear=0 we=0 busy=1",
                         k, mmu_en, mmu_clear, mem_we, busy);
            end
        end
        @(negedge clk);
        c00 = r0;
        c01 = r1;
        c10 = r2;
        c11 = r3;
        load_en = pulse;
        #1;
        total++;
        if (mmu_en !== 1'b0 || out_valid !== 1'b0 || mem_we !== 1'b0) begin
            bad++;
            $display("FAIL capture_cycle: got en=%b valid=%b we=%b want 0 0 0", mmu_en, out_valid, mem_we);
        end
    endtask

    // Drains the 8 result bytes; stall uses the ready pattern 1,0,0,1.
    task automatic do_output(input logic [15:0] r0, input logic [15:0] r1,
                             input logic [15:0] r2, input logic [15:0] r3,
                             input bit stall, input bit pulse);
        logic [7:0] exp_b [8];
        int idx;
        int cyc;
        exp_b[0] = r0[7:0]; exp_b[1] = r0[15:8];
        exp_b[2] = r1[7:0]; exp_b[3] = r1[15:8];
        exp_b[4] = r2[7:0]; exp_b[5] = r2[15:8];
        exp_b[6] = r3[7:0]; exp_b[7] = r3[15:8];
        idx = 0;
        cyc = 0;
        while (idx < 8 && cyc < 64) begin
            @(negedge clk);
            if (cyc == 0) begin
                c00 = 16'hDEAD;
                c01 = 16'hBEEF;
                c10 = 16'hF00D;
                c11 = 16'hCAFE;
            end
            out_ready = stall ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            load_en = pulse && ((cyc % 2) == 0);
            in_data = 8'h5A;
            #1;
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_b[idx]) begin
                bad++;
                $display("FAIL out_byte[%0d] cyc %0d: got valid=%b data=%h want valid=1 data=%h",
                         idx, cyc, out_valid, out_data, exp_b[idx]);
            end
            total++;
            if (mem_we !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL out_ctrl[cyc %0d]: got we=%b busy=%b done=%b want 0 1 0",
                         cyc, mem_we, busy, done);
            end
            if (out_ready) idx++;
            cyc++;
        end
        total++;
        if (idx != 8) begin
            bad++;
            $display("FAIL out_count: got %0d transfers want 8", idx);
        end
        @(negedge clk);
        out_ready = 1'b1;
        load_en = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse: got valid=%b done=%b busy=%b want 0 1 0", out_valid, done, busy);
        end
        @(negedge clk);
        #1;
        total++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL done_clear: got done=%b valid=%b want 0 0", done, out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        load_en = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || mmu_en !== 1'b0 || mmu_clear !== 1'b0 || out_valid !== 1'b0 ||
            done !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 3'd0) begin
            bad++;
            $display("FAIL reset_state: got busy=%b en=%b clear=%b valid=%b done=%b we=%b addr=%0d want all 0",
                     busy, mmu_en, mmu_clear, out_valid, done, mem_we, mem_addr);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        do_load(1'b0, 8'd1);
        do_compute(16'd19, 16'd22, 16'd43, 16'd50, 1'b0);
        do_output(16'd19, 16'd22, 16'd43, 16'd50, 1'b0, 1'b0);
    endtask

    task automatic test_gaps_and_stall();
        do_load(1'b1, 8'hA0);
        do_compute(16'h1234, 16'h5678, 16'h9ABC, 16'hABCD, 1'b0);
        do_output(16'h1234, 16'h5678, 16'h9ABC, 16'hABCD, 1'b1, 1'b0);
    endtask

    task automatic test_ignored_load();
        do_load(1'b0, 8'h10);
        do_compute(16'h00FF, 16'hFF00, 16'h8001, 16'h7FFE, 1'b1);
        do_output(16'h00FF, 16'hFF00, 16'h8001, 16'h7FFE, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        do_load(1'b0, 8'h40);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            total++;
            if (mmu_en !== 1'b1) begin
                bad++;
                $display("FAIL mid_compute[%0d]: got en=%b want 1", k, mmu_en);
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (mmu_en !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || mem_addr !== 3'd0) begin
            bad++;
            $display("FAIL mid_reset: got en=%b valid=%b busy=%b addr=%0d want 0 0 0 0",
                     mmu_en, out_valid, busy, mem_addr);
        end
        do_load(1'b0, 8'h60);
        do_compute(16'h0001, 16'h0002, 16'h0003, 16'h0004, 1'b0);
        do_output(16'h0001, 16'h0002, 16'h0003, 16'h0004, 1'b0, 1'b0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        load_en = 1'b0;
        in_data = 8'h00;
        out_ready = 1'b1;
        c00 = '0;
        c01 = '0;
        c10 = '0;
        c11 = '0;
        test_reset();
        test_back_to_back();
        test_gaps_and_stall();
        test_ignored_load();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tpu_control_unit.md
Name: tpu_control_unit

Overview:
- Sequencer that sits directly upstream of the 8-entry operand memory and downstream of the 2x2 systolic array.
- Turns the host byte stream into memory writes at addresses 0..7: weights W0..W3, then inputs X0..X3.
- Runs the array for a fixed number of cycles, then snapshots the four 16-bit results and serialises them as bytes under a valid/ready handshake.
- Returns to loading for the next matrix pair.

Parameters:
- COMPUTE_CYCLES, 5, number of cycles mmu_en is held high (array fill + drain latency for 2x2).
- N_OPERANDS, 8, bytes accepted per load phase (4 weights + 4 inputs).
- N_OUT_BYTES, 8, bytes emitted per result phase (4 results x 2 bytes).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- load_en  input  1  host strobe: in_data valid this cycle.
- in_data  input  8  host operand byte.
- mem_we  output  1  write enable to operand memory.
- mem_addr  output  3  memory address; bit 2 = 0 selects weights, 1 selects inputs.
- mem_wdata  output  8  memory write data.
- mmu_clear  output  1  one-cycle accumulator clear to the array.
- mmu_en  output  1  array compute enable.
- c00, c01, c10, c11  input  16 each  array results, valid on the cycle after mmu_en falls.
- out_data  output  8  result byte.
- out_valid  output  1  out_data valid.
- out_ready  input  1  host accepts out_data.
- busy  output  1  high whenever state is not LOAD.
- done  output  1  one-cycle pulse after the last result byte is accepted.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled on the rising edge of clk.
- Reset values: state = LOAD; load_cnt = 0; cyc_cnt = 0; out_cnt = 0; result shadow = 0. Outputs mmu_en, mmu_clear, out_valid, done, mem_we = 0; mem_addr = 0; busy = 0.
- Reset mid-operation: abandons any phase. Partially loaded memory contents are not cleared; the memory has its own reset.

States:
- LOAD:
  - mem_we = load_en (combinational); mem_addr = load_cnt; mem_wdata = in_data. The memory captures the byte on the same edge.
  - Each accepted byte increments load_cnt.
  - On the edge accepting byte 8 (load_cnt == 7 and load_en): load_cnt -> 0, go to CLEAR.
  - No load_en means no change.
- CLEAR: mmu_clear = 1 for exactly 1 cycle, then go to COMPUTE with cyc_cnt = 0.
- COMPUTE:
  - mmu_en = 1 while cyc_cnt < COMPUTE_CYCLES; cyc_cnt increments each cycle.
  - On the edge where cyc_cnt == COMPUTE_CYCLES-1, go to CAPTURE.
- CAPTURE (1 cycle, mmu_en = 0): register c00, c01, c10, c11 into a 64-bit shadow. Go to OUTPUT with out_cnt = 0.
- OUTPUT:
  - out_valid = 1.
  - Byte order is little-endian per result, row-major: c00[7:0], c00[15:8], c01[7:0], c01[15:8], c10[7:0], c10[15:8], c11[7:0], c11[15:8].
  - out_data is selected by out_cnt from the shadow, not from the live array inputs.
  - Transfer occurs when out_valid & out_ready. out_data must hold stable while out_ready = 0.
  - After the transfer at out_cnt == 7: done = 1 for one cycle (registered, asserted the cycle after), state -> LOAD, out_cnt -> 0.

Boundary conditions:
- load_en outside LOAD is ignored: mem_we stays 0 and the byte is dropped, with no error flag.
- busy is a registered decode of state != LOAD.
- Result widths are 16 bits, unsigned. No saturation is performed here; the array owns arithmetic.
- out_ready held high gives 1 byte per cycle. Total latency from the 8th load byte to the first out_valid is 1 + COMPUTE_CYCLES + 1 + 1 cycles (8 with defaults).

Decomposition:
- Shared package tpu_pkg:
  - state enum (LOAD, CLEAR, COMPUTE, CAPTURE, OUTPUT), 3 bits.
  - constants N_OPERANDS, N_OUT_BYTES, RESULT_W = 16, DATA_W = 8.
- One natural sub-module: result_serializer. It holds the 64-bit shadow, out_cnt, the valid/ready handshake and the byte mux, with a start pulse in and a last-byte pulse out. The FSM and counters stay in the top.

Test Plan:
- Reset then load bytes 1, 2, 3, 4, 5, 6, 7, 8 on consecutive cycles -> mem_we high for 8 cycles, mem_addr 0..7 with matching mem_wdata, busy rises the cycle after byte 8.
- Same load with load_en gaps (pattern 1, 0, 1, 1, 0, ...) -> addresses still 0..7 in order, no writes on idle cycles.
- After load, drive c00 = 19, c01 = 22, c10 = 43, c11 = 50 at CAPTURE with out_ready = 1 -> mmu_clear for 1 cycle, mmu_en for 5 cycles, bytes 0x13, 00, 0x16, 00, 0x2B, 00, 0x32, 00, done pulse, busy falls.
- Results c00 = 0x1234, c11 = 0xABCD, out_ready toggled 1, 0, 0, 1, ... -> out_data stable while stalled, byte sequence 34, 12, ..., CD, AB, exactly 8 transfers.
- load_en pulses during COMPUTE and OUTPUT -> no mem_we, output stream unaffected. Next load starts again at addr 0.
- rst_n low for 1 cycle during COMPUTE cycle 3 -> next cycle state LOAD, mmu_en = 0, out_valid = 0, and a fresh 8-byte load starts at addr 0.
